vec_activation: RTL and testbench

Parametrised streaming activation unit, successor to the fixed ReLU stage. It pulls an InVecLength-element signed vector from an upstream VecFIFO in ChunkElems-wide chunks and applies a runtime-selected activation (pass, ReLU, leaky ReLU, clamped ReLU). It pushes result chunks into a downstream VecFIFO and reports completion and a per-vector count of modified elements. It sits between layer FIFOs in the inference datapath.

---
 rtl/vec_activation_pkg.sv | 21 ++
 rtl/vec_activation_if.sv | 34 +++
 rtl/vec_activation_act_lane.sv | 37 +++
 rtl/vec_activation.sv | 113 +++++++++++
 tb/tb_vec_activation.sv | 154 +++++++++++++++
 5 files changed

// File: rtl/vec_activation_pkg.sv
// Shared types for the streaming activation unit: activation modes and
// controller states.
package activation_pkg;

  // Runtime-selected activation function, encoded as on mode_in.
  typedef enum logic [1:0] {
    ACT_PASS  = 2'd0,
    ACT_RELU  = 2'd1,
    ACT_LEAKY = 2'd2,
    ACT_CLAMP = 2'd3
  } act_mode_t;

  // Vector controller states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } act_state_t;

endpackage

// File: rtl/vec_activation_if.sv
// Bus bundle between the activation unit and its surroundings: upstream
// VecFIFO read side, downstream VecFIFO write side, mode and status.
interface vec_activation_if #(
  parameter int ChunkElems  = 4,
  parameter int DataWidth   = 8,
  parameter int InVecLength = 8
) ();
  localparam int ChunkW = ChunkElems * DataWidth;
  localparam int CountW = $clog2(InVecLength + 1);

  logic [1:0]        mode_in;
  logic              in_data_ready;
  logic [ChunkW-1:0] in_data;
  logic              req_chunk_in;
  logic [ChunkW-1:0] write_out_data;
  logic              req_chunk_out;
  logic              out_vector_valid;
  logic              busy;
  logic [CountW-1:0] mod_count;

  // Activation unit side.
  modport slave (
    input  mode_in, in_data_ready, in_data,
    output req_chunk_in, write_out_data, req_chunk_out,
           out_vector_valid, busy, mod_count
  );

  // Surrounding datapath / controller side.
  modport master (
    output mode_in, in_data_ready, in_data,
    input  req_chunk_in, write_out_data, req_chunk_out,
           out_vector_valid, busy, mod_count
  );
endinterface

// File: rtl/vec_activation_act_lane.sv
// Single-element activation: purely combinational, reports whether the
// output differs from the input.
module act_lane
  import activation_pkg::*;
#(
  parameter int DataWidth  = 8,
  parameter int LeakyShift = 3,
  parameter int ClampMax   = 127
) (
  input  logic signed [DataWidth-1:0] x_i,
  input  act_mode_t                   mode_i,
  output logic signed [DataWidth-1:0] y_o,
  output logic                        mod_o
);
  localparam logic signed [DataWidth-1:0] ClampC = DataWidth'(ClampMax);

  logic neg_w;
  assign neg_w = x_i[DataWidth-1];

  // Apply the selected activation and flag lanes that changed value.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    y_o = x_i;
    case (mode_i)
      ACT_PASS:  y_o = x_i;
      ACT_RELU:  if (neg_w) y_o = '0;
      ACT_LEAKY: if (neg_w) y_o = x_i >>> LeakyShift;  // floor: -1 stays -1
      ACT_CLAMP: begin
        if (neg_w)            y_o = '0;
        else if (x_i > ClampC) y_o = ClampC;
      end
      default:   y_o = x_i;
    endcase
    mod_o = (y_o != x_i);
  end
endmodule

// File: rtl/vec_activation.sv
// Streaming activation unit: pulls a vector chunk by chunk from an upstream
// FIFO, activates every lane, pushes result chunks downstream and reports
// completion plus the number of modified elements.
module vec_activation
  import activation_pkg::*;
#(
  parameter int InVecLength = 8,
  parameter int ChunkElems  = 4,
  parameter int DataWidth   = 8,
  parameter int LeakyShift  = 3,
  parameter int ClampMax    = 127
) (
  input logic        clk_in,
  input logic        rst_in,
  vec_activation_if.slave bus
);
  localparam int NumChunks = InVecLength / ChunkElems;
  localparam int CntW      = $clog2(NumChunks) + 1;
  localparam int CountW    = $clog2(InVecLength + 1);
  localparam int ChunkW    = ChunkElems * DataWidth;

  act_state_t        state_q, state_d;
  act_mode_t         mode_q;
  logic              req_q, rdv_q, wr_q, busy_q, ovv_q;
  logic [CntW-1:0]   req_cnt_q, wr_cnt_q;
  logic [CountW-1:0] run_cnt_q, mod_q, chunk_mods;
  logic [ChunkW-1:0] data_q, lane_y;
  logic [ChunkElems-1:0] lane_mod;
  logic              start_w, last_req_w, last_wr_w;

  for (genvar g = 0; g < ChunkElems; g++) begin : g_lane
    act_lane #(
      .DataWidth (DataWidth),
      .LeakyShift(LeakyShift),
      .ClampMax  (ClampMax)
    ) u_lane (
      .x_i   (bus.in_data[g*DataWidth +: DataWidth]),
      .mode_i(mode_q),
      .y_o   (lane_y[g*DataWidth +: DataWidth]),
      .mod_o (lane_mod[g])
    );
  end

  // Count modified lanes in the chunk currently arriving from upstream.
  always_comb begin
    chunk_mods = '0;
    for (int i = 0; i < ChunkElems; i++) chunk_mods = chunk_mods + CountW'(lane_mod[i]);
  end

  assign start_w    = bus.in_data_ready && (state_q == IDLE || state_q == DONE);
  assign last_req_w = (state_q == STREAM) && (req_cnt_q == CntW'(NumChunks - 1));
  assign last_wr_w  = (state_q == DRAIN) && wr_q && (wr_cnt_q == CntW'(NumChunks - 1));

  // Next-state logic; start requests while busy are ignored.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (bus.in_data_ready) state_d = STREAM;
      STREAM:     if (last_req_w) state_d = DRAIN;
      DRAIN:      if (last_wr_w) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  // Controller, request/write counters, 2-stage valid pipeline and counters.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q   <= IDLE;
      mode_q    <= ACT_PASS;
      req_q     <= 1'b0;
      rdv_q     <= 1'b0;
      wr_q      <= 1'b0;
      busy_q    <= 1'b0;
      ovv_q     <= 1'b0;
      req_cnt_q <= '0;
      wr_cnt_q  <= '0;
      run_cnt_q <= '0;
      mod_q     <= '0;
      data_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q <= state_d;
      busy_q  <= (state_d == STREAM) || (state_d == DRAIN);
      req_q   <= (state_d == STREAM);
      rdv_q   <= req_q;   // upstream data valid the cycle after a request
      wr_q    <= rdv_q;   // result registered one cycle after data arrives
      if (rdv_q) data_q <= lane_y;
      if (start_w) begin
        mode_q    <= act_mode_t'(bus.mode_in);
        req_cnt_q <= '0;
        wr_cnt_q  <= '0;
        run_cnt_q <= '0;
        ovv_q     <= 1'b0;
      end else begin
        if (req_q) req_cnt_q <= req_cnt_q + CntW'(1);
        if (wr_q)  wr_cnt_q  <= wr_cnt_q + CntW'(1);
        if (rdv_q) run_cnt_q <= run_cnt_q + chunk_mods;
        if (last_wr_w) begin
          ovv_q <= 1'b1;
          mod_q <= run_cnt_q;
        end
      end
    end
  end

  assign bus.req_chunk_in     = req_q;
  assign bus.req_chunk_out    = wr_q;
  assign bus.write_out_data   = data_q;
  assign bus.out_vector_valid = ovv_q;
  assign bus.busy             = busy_q;
  assign bus.mod_count        = mod_q;
endmodule

// File: tb/tb_vec_activation.sv
// Directed bench for vec_activation: activation modes, cycle timing,
// mid-stream reset and back-to-back vectors.
module tb_vec_activation;
  import activation_pkg::*;

  localparam int N = 2;  // chunks per vector with 8 elements, 4 per chunk
  localparam logic [31:0] IdleData = 32'h5a5a5a5a;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   model_mod = 0;
  logic [63:0] v;

  always #5 clk = ~clk;

  vec_activation_if #(.ChunkElems(4), .DataWidth(8), .InVecLength(8)) vif ();

  vec_activation #(
    .InVecLength(8), .ChunkElems(4), .DataWidth(8), .LeakyShift(3), .ClampMax(6)
  ) dut (
    .clk_in(clk),
    .rst_in(rst),
    .bus   (vif)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Element 0 lands in the least significant byte.
  function automatic logic [63:0] pack8(input int e0, input int e1, input int e2, input int e3,
                                        input int e4, input int e5, input int e6, input int e7);
    return {e7[7:0], e6[7:0], e5[7:0], e4[7:0], e3[7:0], e2[7:0], e1[7:0], e0[7:0]};
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, " req_in"},  vif.req_chunk_in, 1'b0);
    check({tag, " req_out"}, vif.req_chunk_out, 1'b0);
    check({tag, " data"},    vif.write_out_data, 32'h0);
    check({tag, " ovv"},     vif.out_vector_valid, 1'b0);
    check({tag, " busy"},    vif.busy, 1'b0);
    check({tag, " mod"},     vif.mod_count, 4'd0);
  endtask

  task automatic start(input logic [1:0] m);
    @(negedge clk);
    vif.mode_in       = m;
    vif.in_data_ready = 1'b1;
  endtask

  // Cycle k = 1..N+3 after the start edge; acts as the upstream FIFO too.
  task automatic stream_vec(input logic [63:0] vin, input logic [63:0] vexp, input int exp_mod,
                            input bit hold, input logic [1:0] next_mode, input string tag);
    bit pend = 1'b0;
    int rd = 0;
    for (int k = 1; k <= N + 3; k++) begin
      @(negedge clk);
      if (!hold) vif.in_data_ready = 1'b0;
      check($sformatf("%s c%0d req_in", tag, k),  vif.req_chunk_in, (k <= N));
      check($sformatf("%s c%0d req_out", tag, k), vif.req_chunk_out, (k >= 3 && k <= N + 2));
      check($sformatf("%s c%0d busy", tag, k),    vif.busy, (k <= N + 2));
      check($sformatf("%s c%0d ovv", tag, k),     vif.out_vector_valid, (k == N + 3));
      check($sformatf("%s c%0d mod", tag, k),     vif.mod_count,
            (k == N + 3) ? 64'(exp_mod) : 64'(model_mod));
      if (k >= 3 && k <= N + 2)
        check($sformatf("%s c%0d data", tag, k), vif.write_out_data, vexp[(k-3)*32 +: 32]);
      if (pend) begin
        vif.in_data = vin[rd*32 +: 32];
        rd++;
      end else begin
        vif.in_data = IdleData;
      end
      pend = vif.req_chunk_in && (rd < N);
      if (hold && k == N + 3) vif.mode_in = next_mode;
    end
    model_mod = exp_mod;
  endtask

  initial begin
    rst               = 1'b1;
    vif.mode_in       = 2'd0;
    vif.in_data_ready = 1'b0;
    vif.in_data       = '0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    // ReLU
    start(2'd1);
    stream_vec(pack8(0, 0, -1, 1, -2, 2, -3, 3), pack8(0, 0, 0, 1, 0, 2, 0, 3), 3, 0, 2'd0, "relu");

    // Leaky ReLU, shift 3
    start(2'd2);
    stream_vec(pack8(-8, -1, -128, 5, 0, -16, 127, -2),
               pack8(-1, -1, -16, 5, 0, -2, 127, -1), 4, 0, 2'd0, "leaky");

    // Clamped ReLU, max 6
    start(2'd3);
    stream_vec(pack8(7, 127, -5, 6, 0, 1, -128, 100),
               pack8(6, 6, 0, 6, 0, 1, 0, 6), 5, 0, 2'd0, "clamp");

    // Mid-stream: start/mode changes ignored, then asynchronous reset
    v = pack8(0, 0, -1, 1, -2, 2, -3, 3);
    start(2'd1);
    @(negedge clk);  // cycle 1
    vif.in_data_ready = 1'b0;
    vif.in_data       = IdleData;
    check("mid c1 req_in", vif.req_chunk_in, 1'b1);
    check("mid c1 busy", vif.busy, 1'b1);
    check("mid c1 ovv", vif.out_vector_valid, 1'b0);
    @(negedge clk);  // cycle 2
    check("mid c2 req_in", vif.req_chunk_in, 1'b1);
    vif.in_data       = v[31:0];
    vif.in_data_ready = 1'b1;
    vif.mode_in       = 2'd0;
    @(negedge clk);  // cycle 3
    vif.in_data       = IdleData;
    vif.in_data_ready = 1'b0;
    check("mid c3 req_in", vif.req_chunk_in, 1'b0);
    check("mid c3 busy", vif.busy, 1'b1);
    check("mid c3 req_out", vif.req_chunk_out, 1'b1);
    check("mid c3 data", vif.write_out_data, 32'h01000000);
    check("mid c3 mod", vif.mod_count, 4'd5);
    rst = 1'b1;
    #1;
    check_all_zero("midrst");
    @(negedge clk);
    rst = 1'b0;
    model_mod = 0;
    @(negedge clk);
    check("post_rst req_in", vif.req_chunk_in, 1'b0);
    check("post_rst busy", vif.busy, 1'b0);

    // Fresh start in pass mode: timing and identity output
    v = pack8(1, -2, 3, -4, 100, -100, 127, -128);
    start(2'd0);
    stream_vec(v, v, 0, 0, 2'd0, "pass");

    // Back-to-back: start held through DONE, mode relatched for vector two
    start(2'd1);
    stream_vec(pack8(0, 0, -1, 1, -2, 2, -3, 3), pack8(0, 0, 0, 1, 0, 2, 0, 3), 3, 1, 2'd2, "b2b_a");
    stream_vec(pack8(-8, -1, -128, 5, 0, -16, 127, -2),
               pack8(-1, -1, -16, 5, 0, -2, 127, -1), 4, 0, 2'd0, "b2b_b");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
